// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_types (package)
// Description : Shared types for the writeback path: the CDB broadcast record
//               and default physical-register / ROB index widths.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

  localparam int c_PHYS_REG_BITS = 6;
  localparam int c_ROB_IDX_BITS  = 5;

  typedef struct packed {
    logic                       valid;
    logic [c_PHYS_REG_BITS-1:0] pd;
    logic [c_ROB_IDX_BITS-1:0]  rob;
    logic [31:0]                data;
  } cdb_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. It searches from ptr upward
//               (mod NUM_REQ) and returns a one-hot grant for the first request.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int PTR_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [PTR_BITS-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant
);

  localparam int c_SUM_BITS = PTR_BITS + 1;

  logic [c_SUM_BITS-1:0] w_sum;
  logic                  w_found;

  // ptr + i stays below 2*NUM_REQ, so a single conditional subtract wraps it
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, ptr} + c_SUM_BITS'(i);
      if (w_sum >= c_SUM_BITS'(NUM_REQ)) begin
        w_sum = w_sum - c_SUM_BITS'(NUM_REQ);
      end
      if (!w_found && req[w_sum[PTR_BITS-1:0]]) begin
        grant[w_sum[PTR_BITS-1:0]] = 1'b1;
        w_found                    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Round-robin arbitration of functional-unit writebacks onto a
//               single registered common data bus and regfile write port.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int PHYS_REG_BITS = c_PHYS_REG_BITS,
  parameter int ROB_IDX_BITS  = c_ROB_IDX_BITS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*PHYS_REG_BITS-1:0] req_pd,
  input  logic [NUM_REQ*ROB_IDX_BITS-1:0]  req_rob,
  input  logic [NUM_REQ*32-1:0]            req_data,
  output logic                             cdb_valid,
  output logic [PHYS_REG_BITS-1:0]         cdb_pd,
  output logic [ROB_IDX_BITS-1:0]          cdb_rob,
  output logic [31:0]                      cdb_data,
  output logic                             regf_we,
  output logic [PHYS_REG_BITS-1:0]         regf_rd_s,
  output logic [31:0]                      regf_rd_v
);

  localparam int c_PTR_BITS = $clog2(NUM_REQ);

  cdb_t                     r_out;
  logic [c_PTR_BITS-1:0]    r_ptr;
  logic [NUM_REQ-1:0]       w_req;
  logic [NUM_REQ-1:0]       w_grant;
  logic [c_PTR_BITS-1:0]    w_gnt_idx;
  logic [c_PTR_BITS-1:0]    w_ptr_next;
  logic [PHYS_REG_BITS-1:0] w_pd;
  logic [ROB_IDX_BITS-1:0]  w_rob;
  logic [31:0]              w_data;

  // Masking the requests (not the grant) keeps ready low during flush and reset
  assign w_req = req_valid & {NUM_REQ{~flush & ~rst}};

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .PTR_BITS (c_PTR_BITS)
  ) u_rr_arbiter (
    .req   (w_req),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  assign req_ready = w_grant;

  always_comb begin
    w_gnt_idx = '0;
    w_pd      = '0;
    w_rob     = '0;
    w_data    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gnt_idx = c_PTR_BITS'(i);
        w_pd      = req_pd[i*PHYS_REG_BITS +: PHYS_REG_BITS];
        w_rob     = req_rob[i*ROB_IDX_BITS +: ROB_IDX_BITS];
        w_data    = req_data[i*32 +: 32];
      end
    end
  end

  assign w_ptr_next = (w_gnt_idx == c_PTR_BITS'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  // Payload only loads on a grant so the bus holds its last value when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
      r_ptr <= '0;
    end else begin
      r_out.valid <= |w_grant;
      if (|w_grant) begin
        r_out.pd   <= w_pd;
        r_out.rob  <= w_rob;
        r_out.data <= w_data;
        r_ptr      <= w_ptr_next;
      end
    end
  end

  assign cdb_valid = r_out.valid;
  assign cdb_pd    = r_out.pd;
  assign cdb_rob   = r_out.rob;
  assign cdb_data  = r_out.data;

  // Physical register 0 is hard-wired, so broadcasts to it never write
  assign regf_we   = r_out.valid && (r_out.pd != '0);
  assign regf_rd_s = r_out.pd;
  assign regf_rd_v = r_out.data;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Directed and randomized self-checking bench for cdb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int PB = 6;
  localparam int RB = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*PB-1:0] req_pd = '0;
  logic [N*RB-1:0] req_rob = '0;
  logic [N*32-1:0] req_data = '0;
  logic            cdb_valid;
  logic [PB-1:0]   cdb_pd;
  logic [RB-1:0]   cdb_rob;
  logic [31:0]     cdb_data;
  logic            regf_we;
  logic [PB-1:0]   regf_rd_s;
  logic [31:0]     regf_rd_v;

  int checks = 0;
  int fails  = 0;

  cdb_arbiter #(.NUM_REQ(N), .PHYS_REG_BITS(PB), .ROB_IDX_BITS(RB)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pd    (req_pd),
    .req_rob   (req_rob),
    .req_data  (req_data),
    .cdb_valid (cdb_valid),
    .cdb_pd    (cdb_pd),
    .cdb_rob   (cdb_rob),
    .cdb_data  (cdb_data),
    .regf_we   (regf_we),
    .regf_rd_s (regf_rd_s),
    .regf_rd_v (regf_rd_v)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [PB-1:0] pd, input logic [RB-1:0] rob,
                         input logic [31:0] data);
    req_pd[i*PB +: PB]   = pd;
    req_rob[i*RB +: RB]  = rob;
    req_data[i*32 +: 32] = data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    checks++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL reset_cdb_valid got %b exp 0", cdb_valid); end
    checks++; if (regf_we !== 1'b0) begin fails++; $display("FAIL reset_regf_we got %b exp 0", regf_we); end
    checks++; if ({cdb_pd, cdb_rob, cdb_data} !== '0) begin fails++;
      $display("FAIL reset_payload got pd=%h rob=%h data=%h exp 0", cdb_pd, cdb_rob, cdb_data); end
    checks++; if (dut.r_ptr !== 2'd0) begin fails++; $display("FAIL reset_ptr got %0d exp 0", dut.r_ptr); end
    req_valid = '1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    req_valid = '0;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++) set_req(i, PB'(i + 1), RB'(16 + i), 32'hA000_0000 + i);
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_rdy = N'(1) << (k % N);
      checks++; if (req_ready !== exp_rdy) begin fails++;
        $display("FAIL rr_grant cycle %0d got %b exp %b", k, req_ready, exp_rdy); end
      tick();
      checks++; if (cdb_valid !== 1'b1 || cdb_rob !== RB'(16 + (k % N))) begin fails++;
        $display("FAIL rr_cdb cycle %0d got v=%b rob=%0d exp v=1 rob=%0d", k, cdb_valid, cdb_rob, 16 + (k % N)); end
    end
    req_valid = '0;
    tick();
    checks++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL rr_idle got %b exp 0", cdb_valid); end
    checks++; if (dut.r_ptr !== 2'd0) begin fails++; $display("FAIL rr_ptr got %0d exp 0", dut.r_ptr); end
  endtask

  task automatic test_zero_pd();
    set_req(2, 6'd0, 5'd7, 32'hDEAD_BEEF);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL zpd_ready got %b exp 0100", req_ready); end
    tick();
    checks++; if (cdb_valid !== 1'b1 || cdb_data !== 32'hDEAD_BEEF) begin fails++;
      $display("FAIL zpd_cdb got v=%b data=%h exp v=1 data=deadbeef", cdb_valid, cdb_data); end
    checks++; if (regf_we !== 1'b0) begin fails++; $display("FAIL zpd_regf_we got %b exp 0", regf_we); end
    checks++; if (regf_rd_v !== 32'hDEAD_BEEF) begin fails++; $display("FAIL zpd_rd_v got %h exp deadbeef", regf_rd_v); end
    req_valid = '0;
    tick();
    checks++; if (cdb_valid !== 1'b0 || cdb_data !== 32'hDEAD_BEEF) begin fails++;
      $display("FAIL zpd_hold got v=%b data=%h exp v=0 data=deadbeef", cdb_valid, cdb_data); end
    checks++; if (dut.r_ptr !== 2'd3) begin fails++; $display("FAIL zpd_ptr got %0d exp 3", dut.r_ptr); end
  endtask

  task automatic test_ptr_skip();
    set_req(1, 6'd9, 5'd11, 32'h1111_1111);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL skip_setup got %b exp 0010", req_ready); end
    tick();
    checks++; if (dut.r_ptr !== 2'd2) begin fails++; $display("FAIL skip_ptr_setup got %0d exp 2", dut.r_ptr); end
    set_req(3, 6'd12, 5'd13, 32'h3333_3333);
    req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL skip_grant3 got %b exp 1000", req_ready); end
    tick();
    checks++; if (cdb_rob !== 5'd13 || dut.r_ptr !== 2'd0) begin fails++;
      $display("FAIL skip_cdb3 got rob=%0d ptr=%0d exp rob=13 ptr=0", cdb_rob, dut.r_ptr); end
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL skip_grant1 got %b exp 0010", req_ready); end
    tick();
    checks++; if (cdb_rob !== 5'd11 || cdb_data !== 32'h1111_1111) begin fails++;
      $display("FAIL skip_cdb1 got rob=%0d data=%h exp rob=11 data=11111111", cdb_rob, cdb_data); end
    checks++; if (dut.r_ptr !== 2'd2) begin fails++; $display("FAIL skip_ptr_end got %0d exp 2", dut.r_ptr); end
  endtask

  task automatic test_flush();
    set_req(0, 6'd5, 5'd3, 32'h5555_0000);
    req_valid = 4'b0001;
    flush = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL flush_ready got %b exp 0000", req_ready); end
    tick();
    checks++; if (cdb_valid !== 1'b0 || regf_we !== 1'b0) begin fails++;
      $display("FAIL flush_cdb got v=%b we=%b exp 0 0", cdb_valid, regf_we); end
    checks++; if (dut.r_ptr !== 2'd2) begin fails++; $display("FAIL flush_ptr got %0d exp 2", dut.r_ptr); end
    flush = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL flush_resume got %b exp 0001", req_ready); end
    tick();
    checks++; if (cdb_valid !== 1'b1 || regf_we !== 1'b1 || regf_rd_s !== 6'd5) begin fails++;
      $display("FAIL flush_after got v=%b we=%b rd_s=%0d exp 1 1 5", cdb_valid, regf_we, regf_rd_s); end
    checks++; if (dut.r_ptr !== 2'd1) begin fails++; $display("FAIL flush_after_ptr got %0d exp 1", dut.r_ptr); end
  endtask

  task automatic test_reset_mid();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (cdb_valid !== 1'b0 || regf_we !== 1'b0) begin fails++;
      $display("FAIL amid_out got v=%b we=%b exp 0 0", cdb_valid, regf_we); end
    checks++; if (dut.r_ptr !== 2'd0 || cdb_data !== 32'd0) begin fails++;
      $display("FAIL amid_state got ptr=%0d data=%h exp 0 0", dut.r_ptr, cdb_data); end
    checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL amid_ready got %b exp 0000", req_ready); end
    set_req(1, 6'd21, 5'd21, 32'h2121_2121);
    req_valid = 4'b0110;
    tick();
    checks++; if (req_ready !== 4'b0000 || cdb_valid !== 1'b0) begin fails++;
      $display("FAIL amid_held got rdy=%b v=%b exp 0000 0", req_ready, cdb_valid); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL amid_resume got %b exp 0010", req_ready); end
    tick();
    checks++; if (cdb_valid !== 1'b1 || cdb_rob !== 5'd21 || dut.r_ptr !== 2'd2) begin fails++;
      $display("FAIL amid_first got v=%b rob=%0d ptr=%0d exp 1 21 2", cdb_valid, cdb_rob, dut.r_ptr); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    int            wait_cnt [N];
    logic [N-1:0]  rdy;
    logic          exp_v;
    logic [PB-1:0] exp_pd;
    logic [RB-1:0] exp_rob;
    logic [31:0]   exp_data;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 99) < 50) begin
          set_req(i, PB'($urandom), RB'($urandom), $urandom);
          req_valid[i] = 1'b1;
        end
      end
      #1;
      rdy = req_ready;
      checks++; if (!$onehot0(rdy) || (rdy & ~req_valid) != '0) begin fails++;
        $display("FAIL rand_ready cycle %0d got %b valid %b exp one-hot subset", c, rdy, req_valid); end
      exp_v = 1'b0; exp_pd = '0; exp_rob = '0; exp_data = '0;
      for (int i = 0; i < N; i++) begin
        if (rdy[i]) begin
          exp_v    = 1'b1;
          exp_pd   = req_pd[i*PB +: PB];
          exp_rob  = req_rob[i*RB +: RB];
          exp_data = req_data[i*32 +: 32];
          wait_cnt[i] = 0;
        end else if (req_valid[i]) begin
          wait_cnt[i]++;
          checks++; if (wait_cnt[i] > N - 1) begin fails++;
            $display("FAIL rand_starve cycle %0d req %0d waited %0d exp <= %0d", c, i, wait_cnt[i], N - 1); end
        end
      end
      tick();
      checks++; if (cdb_valid !== exp_v) begin fails++;
        $display("FAIL rand_valid cycle %0d got %b exp %b", c, cdb_valid, exp_v); end
      if (exp_v) begin
        checks++; if (cdb_pd !== exp_pd || cdb_rob !== exp_rob || cdb_data !== exp_data) begin fails++;
          $display("FAIL rand_payload cycle %0d got %h/%h/%h exp %h/%h/%h", c, cdb_pd, cdb_rob, cdb_data,
                   exp_pd, exp_rob, exp_data); end
      end
      req_valid = req_valid & ~rdy;
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_zero_pd();
    test_ptr_skip();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
